// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front-end: operation encodings,
// sequencer state encoding and the fixed divide-by-zero result word.
package calc_pkg;

    // Operation codes understood by the combinational calculator
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Result word substituted for a division by zero when the guard is built in
    localparam logic [15:0] DIVZERO_RESULT = 16'hFFFF;

    // Frame sequencer states: three byte-collection states, one calculate
    // cycle and an output hold state
    typedef enum logic [2:0] {
        GET_OP,
        GET_A,
        GET_B,
        CALC,
        OUT
    } state_t;

    // True in the states that sit between the first and last byte of a frame,
    // where an idle input stream counts towards the inter-byte timeout
    function automatic logic isFrameBody(input state_t s);
        return (s == GET_A) || (s == GET_B);
    endfunction

    // True in every state that is willing to take a byte from the stream
    function automatic logic acceptsByte(input state_t s);
        return (s == GET_OP) || (s == GET_A) || (s == GET_B);
    endfunction

endpackage

// File: rtl/calc_timeout_ctr.sv
// Idle-cycle counter used by stream front-ends to drop stalled frames.
// expire_o rises combinationally in the cycle that would make the LIMIT-th
// consecutive enabled cycle; the counter restarts from zero after that cycle.
// LIMIT = 0 disables expiry entirely.
module calc_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW        = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam int unsigned LAST      = (LIMIT == 0) ? 0 : LIMIT - 1;
    localparam logic        HAS_LIMIT = (LIMIT != 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          atLast;

    assign atLast   = (count_q == CW'(LAST));
    assign expire_o = HAS_LIMIT & enable_i & ~clear_i & atLast;

    // Next count: restart on clear or on expiry, otherwise advance while enabled
    always_comb begin
        count_d = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (enable_i && HAS_LIMIT) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/calc_frame_sequencer.sv
// Front-end for the combinational calculator. Collects op / first / second
// bytes from a valid/ready stream, presents them to the calculator, captures
// the 16-bit answer one cycle later and holds it on a valid/ready output.
// A stalled partial frame is dropped after TIMEOUT_CYCLES idle cycles.
// Build option: define CALC_DIVZERO_GUARD_EN to replace any division by zero
// with DIVZERO_RESULT flagged by out_err.
module calc_frame_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [7:0]  calc_first,
    output logic [7:0]  calc_second,
    output logic [1:0]  calc_op,
    input  logic [15:0] calc_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_err,
    output logic        frame_abort
);

    state_t      state_q;
    logic [1:0]  calcOp_q;
    logic [7:0]  calcFirst_q;
    logic [7:0]  calcSecond_q;
    logic [15:0] outResult_q;
    logic        outValid_q;
    logic        frameAbort_q;

    logic        inXfer;
    logic        ctrClear;
    logic        ctrEnable;
    logic        timeoutExpire;
    logic        unused_op_bits;

    // Only the low two bits of the op byte select an operation
    assign unused_op_bits = ^in_data[7:2];

    assign in_ready  = acceptsByte(state_q);
    assign inXfer    = in_valid & in_ready;

    // Idle cycles only count while a frame is partially collected; any accepted
    // byte or leaving the frame body restarts the count
    assign ctrEnable = isFrameBody(state_q) & ~inXfer;
    assign ctrClear  = inXfer | ~isFrameBody(state_q);

    calc_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear_i (ctrClear),
        .enable_i(ctrEnable),
        .expire_o(timeoutExpire)
    );

`ifdef CALC_DIVZERO_GUARD_EN
    logic outErr_q;
    logic divByZero;

    assign divByZero = (calcOp_q == OP_DIV) && (calcSecond_q == 8'h00);

    // Error flag follows each captured result and is otherwise left alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outErr_q <= 1'b0;
        end else if (state_q == CALC) begin
            outErr_q <= divByZero;
        end
    end

    assign out_err = outErr_q;
`else
    assign out_err = 1'b0;
`endif

    // Frame sequencing FSM with all calculator-facing and result outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= GET_OP;
            calcOp_q     <= 2'b00;
            calcFirst_q  <= 8'h00;
            calcSecond_q <= 8'h00;
            outResult_q  <= 16'h0000;
            outValid_q   <= 1'b0;
            frameAbort_q <= 1'b0;
        end else begin
            frameAbort_q <= 1'b0;
            case (state_q)
                GET_OP: begin
                    if (inXfer) begin
                        calcOp_q <= in_data[1:0];
                        state_q  <= GET_A;
                    end
                end
                GET_A: begin
                    if (inXfer) begin
                        calcFirst_q <= in_data;
                        state_q     <= GET_B;
                    end else if (timeoutExpire) begin
                        frameAbort_q <= 1'b1;
                        state_q      <= GET_OP;
                    end
                end
                GET_B: begin
                    if (inXfer) begin
                        calcSecond_q <= in_data;
                        state_q      <= CALC;
                    end else if (timeoutExpire) begin
                        frameAbort_q <= 1'b1;
                        state_q      <= GET_OP;
                    end
                end
                CALC: begin
`ifdef CALC_DIVZERO_GUARD_EN
                    outResult_q <= divByZero ? DIVZERO_RESULT : calc_result;
`else
                    outResult_q <= calc_result;
`endif
                    outValid_q  <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= GET_OP;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    state_q    <= GET_OP;
                end
            endcase
        end
    end

    assign calc_op     = calcOp_q;
    assign calc_first  = calcFirst_q;
    assign calc_second = calcSecond_q;
    assign out_result  = outResult_q;
    assign out_valid   = outValid_q;
    assign frame_abort = frameAbort_q;

endmodule

// File: tb/tb_calc_frame_sequencer.sv
// Self-checking bench for calc_frame_sequencer with a small behavioural
// calculator attached. Table-driven frames plus hand-written sequences for
// back-pressure, timeout abort, timeout race and asynchronous reset.
module tb_calc_frame_sequencer;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [7:0]  inData;
    logic [7:0]  calcFirst;
    logic [7:0]  calcSecond;
    logic [1:0]  calcOp;
    logic [15:0] calcResult;
    logic        outValid;
    logic        outReady;
    logic [15:0] outResult;
    logic        outErr;
    logic        frameAbort;

    int checkCount;
    int errorCount;
    int abortPulses;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  expOp;
        logic [15:0] expResult;
        logic        expErr;
    } vector_t;

    vector_t vectors[8];

    calc_frame_sequencer #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_data    (inData),
        .calc_first (calcFirst),
        .calc_second(calcSecond),
        .calc_op    (calcOp),
        .calc_result(calcResult),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .out_err    (outErr),
        .frame_abort(frameAbort)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached calculator: subtraction returns the magnitude of the difference,
    // division by zero returns a recognisable junk word
    always_comb begin
        calcResult = 16'h0000;
        case (calcOp)
            2'b00:   calcResult = {8'h00, calcFirst} + {8'h00, calcSecond};
            2'b01:   calcResult = (calcFirst >= calcSecond) ? {8'h00, calcFirst - calcSecond}
                                                            : {8'h00, calcSecond - calcFirst};
            2'b10:   calcResult = {8'h00, calcFirst} * {8'h00, calcSecond};
            default: calcResult = (calcSecond == 8'h00) ? 16'hDEAD : {8'h00, calcFirst / calcSecond};
        endcase
    end

    // Count abort pulses away from the active edge
    always @(negedge clk) begin
        if (frameAbort === 1'b1) abortPulses++;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one byte and hold it until it is accepted at a rising edge
    task automatic sendByte(input logic [7:0] b);
        int waitCycles;
        waitCycles = 0;
        inValid = 1'b1;
        inData  = b;
        while (inReady !== 1'b1 && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (inReady !== 1'b1) checkOutput("in_ready wait", {15'h0, inReady}, 16'h0001);
        tick();
        inValid = 1'b0;
        inData  = 8'h00;
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        sendByte(op);
        sendByte(a);
        sendByte(b);
    endtask

    // Called in the cycle after the last byte: checks the calculate cycle,
    // the result cycle and the return to op collection (out_ready high)
    task automatic finishFrame(input vector_t v, input string tag);
        checkOutput({tag, " calc_op"}, {14'h0, calcOp}, {14'h0, v.expOp});
        checkOutput({tag, " calc_first"}, {8'h0, calcFirst}, {8'h0, v.a});
        checkOutput({tag, " calc_second"}, {8'h0, calcSecond}, {8'h0, v.b});
        checkOutput({tag, " out_valid in CALC"}, {15'h0, outValid}, 16'h0000);
        checkOutput({tag, " in_ready in CALC"}, {15'h0, inReady}, 16'h0000);
        tick();
        checkOutput({tag, " out_valid"}, {15'h0, outValid}, 16'h0001);
        checkOutput({tag, " out_result"}, outResult, v.expResult);
        checkOutput({tag, " out_err"}, {15'h0, outErr}, {15'h0, v.expErr});
        tick();
        checkOutput({tag, " out_valid cleared"}, {15'h0, outValid}, 16'h0000);
        checkOutput({tag, " in_ready back"}, {15'h0, inReady}, 16'h0001);
    endtask

    initial begin
        vector_t v;
        int abortsBefore;

        checkCount  = 0;
        errorCount  = 0;
        abortPulses = 0;

        vectors[0] = '{8'h00, 8'h05, 8'h07, 2'b00, 16'h000C, 1'b0};
        vectors[1] = '{8'h01, 8'h03, 8'h0A, 2'b01, 16'h0007, 1'b0};
        vectors[2] = '{8'h02, 8'hFF, 8'hFF, 2'b10, 16'hFE01, 1'b0};
        vectors[3] = '{8'h03, 8'h64, 8'h07, 2'b11, 16'h000E, 1'b0};
        vectors[4] = '{8'h00, 8'hFF, 8'hFF, 2'b00, 16'h01FE, 1'b0};
        vectors[5] = '{8'hFE, 8'h02, 8'h03, 2'b10, 16'h0006, 1'b0};
`ifdef CALC_DIVZERO_GUARD_EN
        vectors[6] = '{8'h03, 8'h09, 8'h00, 2'b11, 16'hFFFF, 1'b1};
`else
        vectors[6] = '{8'h03, 8'h09, 8'h00, 2'b11, 16'hDEAD, 1'b0};
`endif
        vectors[7] = '{8'h01, 8'hC8, 8'h32, 2'b01, 16'h0096, 1'b0};

        rst      = 1'b1;
        inValid  = 1'b0;
        inData   = 8'h00;
        outReady = 1'b1;

        // Reset state
        tick();
        tick();
        checkOutput("reset in_ready", {15'h0, inReady}, 16'h0001);
        checkOutput("reset out_valid", {15'h0, outValid}, 16'h0000);
        checkOutput("reset calc_op", {14'h0, calcOp}, 16'h0000);
        checkOutput("reset calc_first", {8'h0, calcFirst}, 16'h0000);
        checkOutput("reset calc_second", {8'h0, calcSecond}, 16'h0000);
        checkOutput("reset out_result", outResult, 16'h0000);
        checkOutput("reset out_err", {15'h0, outErr}, 16'h0000);
        checkOutput("reset frame_abort", {15'h0, frameAbort}, 16'h0000);
        rst = 1'b0;
        tick();

        // Back-to-back frames from the table
        for (int i = 0; i < 8; i++) begin
            v = vectors[i];
            applyStimulus(v.op, v.a, v.b);
            finishFrame(v, $sformatf("vec%0d", i));
        end

        // Operands persist while idle
        tick();
        tick();
        checkOutput("retain calc_first", {8'h0, calcFirst}, 16'h00C8);
        checkOutput("retain calc_second", {8'h0, calcSecond}, 16'h0032);

        // Output back-pressure for 10 cycles
        outReady = 1'b0;
        applyStimulus(8'h00, 8'h01, 8'h02);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold out_valid", {15'h0, outValid}, 16'h0001);
            checkOutput("hold out_result", outResult, 16'h0003);
            checkOutput("hold in_ready", {15'h0, inReady}, 16'h0000);
            tick();
        end
        outReady = 1'b1;
        tick();
        checkOutput("release out_valid", {15'h0, outValid}, 16'h0000);
        checkOutput("release in_ready", {15'h0, inReady}, 16'h0001);

        // Timeout: op byte then four idle cycles drops the frame
        abortsBefore = abortPulses;
        sendByte(8'h00);
        tick();
        tick();
        tick();
        checkOutput("timeout not yet", {15'h0, frameAbort}, 16'h0000);
        checkOutput("timeout still GET_A", {15'h0, inReady}, 16'h0001);
        tick();
        checkOutput("timeout frame_abort", {15'h0, frameAbort}, 16'h0001);
        tick();
        checkOutput("timeout pulse ends", {15'h0, frameAbort}, 16'h0000);
        checkOutput("timeout pulse count", 16'(abortPulses - abortsBefore), 16'h0001);
        applyStimulus(8'h00, 8'h01, 8'h01);
        finishFrame('{8'h00, 8'h01, 8'h01, 2'b00, 16'h0002, 1'b0}, "after abort");

        // Transfer in the would-be expiring cycle wins; counter restarts per byte
        abortsBefore = abortPulses;
        sendByte(8'h00);
        tick();
        tick();
        tick();
        sendByte(8'h05);
        tick();
        tick();
        tick();
        sendByte(8'h07);
        finishFrame('{8'h00, 8'h05, 8'h07, 2'b00, 16'h000C, 1'b0}, "late bytes");
        checkOutput("late bytes no abort", 16'(abortPulses - abortsBefore), 16'h0000);

        // Asynchronous reset in the middle of a frame
        sendByte(8'h02);
        sendByte(8'h02);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst calc_op", {14'h0, calcOp}, 16'h0000);
        checkOutput("async rst calc_first", {8'h0, calcFirst}, 16'h0000);
        checkOutput("async rst calc_second", {8'h0, calcSecond}, 16'h0000);
        checkOutput("async rst out_result", outResult, 16'h0000);
        checkOutput("async rst out_valid", {15'h0, outValid}, 16'h0000);
        checkOutput("async rst frame_abort", {15'h0, frameAbort}, 16'h0000);
        checkOutput("async rst in_ready", {15'h0, inReady}, 16'h0001);
        #2;
        rst = 1'b0;
        tick();
        applyStimulus(8'h00, 8'h02, 8'h02);
        finishFrame('{8'h00, 8'h02, 8'h02, 2'b00, 16'h0004, 1'b0}, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/calc_frame_sequencer.md
Name: calc_frame_sequencer

Overview:
Upstream stage for the combinational calculator.
- Collects a 3-byte command frame (operation, first operand, second operand) from a valid/ready byte stream.
- Drives the registered operands and operation into the calculator.
- Captures the 16-bit calculator result one cycle later and presents it on a valid/ready output.
- Also provides an inter-byte timeout and an optional divide-by-zero guard.

Parameters:
TIMEOUT_CYCLES, 255, number of consecutive idle cycles allowed mid-frame (GET_A/GET_B) before the frame is dropped; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  byte on in_data is valid
in_ready  output  1  sequencer accepts a byte this cycle
in_data  input  8  frame byte; byte0 = op (bits[1:0] used, bits[7:2] ignored), byte1 = first operand, byte2 = second operand
calc_first  output  8  registered first operand to calculator
calc_second  output  8  registered second operand to calculator
calc_op  output  2  registered operation to calculator (00 add, 01 sub, 10 mul, 11 div)
calc_result  input  16  combinational result returned by calculator
out_valid  output  1  out_result holds a completed result
out_ready  input  1  consumer accepts out_result
out_result  output  16  captured result
out_err  output  1  qualifies out_result; divide-by-zero (only with guard enabled)
frame_abort  output  1  one-cycle pulse when a partial frame is dropped on timeout

Behaviour:
- Reset (asynchronous): state GET_OP; calc_first, calc_second, calc_op, out_result, out_err, frame_abort, out_valid and the timeout counter all 0. Reset mid-frame discards any partial frame.
- Transfer: occurs when in_valid & in_ready are high at a rising edge.
- in_ready: 1 only in GET_OP, GET_A and GET_B; 0 in CALC and OUT.
- GET_OP: on transfer, calc_op <= in_data[1:0]; go to GET_A.
- GET_A: on transfer, calc_first <= in_data; go to GET_B.
- GET_B: on transfer, calc_second <= in_data; go to CALC.
- CALC: lasts exactly one cycle. Operands are stable for the whole cycle; at its closing edge, out_result <= calc_result, out_valid <= 1, go to OUT.
- OUT: out_valid held at 1 and out_result held stable until out_valid & out_ready. On that edge: out_valid <= 0, go to GET_OP.
- Latency: if the byte2 transfer is in cycle n, then cycle n+1 is CALC and out_valid=1 from cycle n+2. Minimum frame period is 5 cycles with out_ready tied high.
- calc_* outputs keep their last values after a frame until overwritten.
- Timeout: the counter increments each cycle spent in GET_A or GET_B without a transfer, and clears on any transfer or on entry to GET_OP.
  - When the count reaches TIMEOUT_CYCLES, go to GET_OP and pulse frame_abort high for 1 cycle.
  - A transfer in the expiring cycle wins: the byte is accepted and no abort occurs.
- No timeout applies in GET_OP or OUT. Back-pressure in OUT is unbounded.
- Width rules: no arithmetic is performed here; calc_result is captured verbatim, 16 bits.

Optional Feature:
CALC_DIVZERO_GUARD_EN
- Defined: in CALC, if calc_op==2'b11 and calc_second==0, then out_result <= 16'hFFFF and out_err <= 1, and calc_result is ignored. Otherwise out_err <= 0. out_err is updated only at the CALC capture edge.
- Undefined: out_err is tied to 0 and calc_result is always captured unchanged.

Decomposition:
- Package calc_pkg holds:
  - op encoding: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - state enum: GET_OP, GET_A, GET_B, CALC, OUT
  - DIVZERO_RESULT=16'hFFFF
- One sub-module is natural: calc_timeout_ctr, the parameterised idle counter with clear/enable inputs and an expire output, also instantiated by other stream front-ends.

Test Plan:
- Bytes 00,05,07 with out_ready=1, calculator attached -> out_result=16'd12 in cycle n+2 after byte2, out_err=0.
- Bytes 01,03,0A -> calc_op=01, calc_first=3, calc_second=10, out_result=16'd7. Bytes 02,FF,FF -> out_result=16'hFE01.
- out_ready held 0 for 10 cycles after result -> out_valid and out_result stable, in_ready=0. Then out_ready=1 -> in_ready=1 next cycle.
- TIMEOUT_CYCLES=4: send 00, then in_valid=0 for 4 cycles -> frame_abort pulses once, state GET_OP. Next frame 00,01,01 -> result 2.
- Guard enabled: bytes 03,09,00 -> out_result=16'hFFFF, out_err=1. Guard disabled: same frame -> out_err=0.
- Assert rst asynchronously after byte1 -> all outputs 0 immediately. After release, frame 00,02,02 -> result 4.
